// File: rtl/mest_pro_ctrl_pkg.sv
// Shared types and constants for the mest_pro instruction sequencer:
// FSM state encoding, fault codes and instruction word field layout.
package mest_pro_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WAIT,
        HALTED,
        ERROR
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_STK_OVF = 2'b01;
    localparam logic [1:0] ERR_STK_UNF = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int INSTR_W = 20;
    localparam int OPC_W   = 4;
    localparam int OPND_W  = 8;
    localparam int OPC_LSB = 16;
    localparam int OP1_LSB = 8;
    localparam int OP2_LSB = 0;

    function automatic logic state_is_busy(input state_e s);
        return (s == FETCH) || (s == LOAD) || (s == ISSUE) || (s == WAIT);
    endfunction

endpackage

// File: rtl/mest_pro_ret_stack.sv
// Return-address stack for the sequencer. Push and pop are never
// requested together; overflow/underflow are guarded by the caller.
module mest_pro_ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_top,
    output logic         o_full,
    output logic         o_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_push && !o_full) begin
            mem_d[IDX_W'(cnt_q)] = i_data;
            cnt_d                = cnt_q + 1'b1;
        end else if (i_pop && !o_empty) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    assign o_full  = (cnt_q == CNT_W'(DEPTH));
    assign o_empty = (cnt_q == '0);
    assign o_top   = o_empty ? '0 : mem_q[IDX_W'(cnt_q - 1'b1)];

endmodule

// File: rtl/mest_pro_ctrl.sv
// Instruction sequencer: fetch / load / issue / wait loop with a return
// stack, exec-done watchdog and latched fault reporting.
module mest_pro_ctrl
    import mest_pro_ctrl_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int STK_DEPTH = 4,
    parameter int TMO_CYC   = 15
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [PC_W-1:0]   i_start_pc,
    output logic              o_imem_rd,
    output logic [PC_W-1:0]   o_imem_addr,
    input  logic [19:0]       i_imem_data,
    output logic              o_execute,
    output logic [3:0]        o_op_code,
    output logic [7:0]        o_operand1,
    output logic [7:0]        o_operand2,
    input  logic              i_exec_done,
    input  logic              i_jump,
    input  logic              i_return_pc,
    input  logic              i_end_of_code,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_busy,
    output logic              o_halted,
    output logic              o_error,
    output logic [1:0]        o_err_code
);

    localparam int WD_W = $clog2(TMO_CYC + 1);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 imem_rd_q, imem_rd_d;
    logic                 execute_q, execute_d;
    logic                 busy_q, busy_d;
    logic                 halted_q, halted_d;
    logic                 error_q, error_d;
    logic [1:0]           err_code_q, err_code_d;

    logic                 stk_clr, stk_push, stk_pop;
    logic                 stk_full, stk_empty;
    logic [PC_W-1:0]      stk_top;
    logic [PC_W-1:0]      pc_inc;
    logic [PC_W-1:0]      jump_target;

    assign pc_inc      = pc_q + 1'b1;
    assign jump_target = PC_W'(ir_q[OP1_LSB +: OPND_W]);

    mest_pro_ret_stack #(
        .DEPTH (STK_DEPTH),
        .W     (PC_W)
    ) u_stk (
        .clk     (clk),
        .rst     (i_reset),
        .i_clr   (stk_clr),
        .i_push  (stk_push),
        .i_pop   (stk_pop),
        .i_data  (pc_inc),
        .o_top   (stk_top),
        .o_full  (stk_full),
        .o_empty (stk_empty)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        wd_d       = wd_q;
        halted_d   = halted_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        stk_clr    = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;

        case (state_q)
            IDLE, HALTED, ERROR: begin
                if (i_start) begin
                    state_d    = FETCH;
                    pc_d       = i_start_pc;
                    stk_clr    = 1'b1;
                    halted_d   = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                ir_d    = i_imem_data;
                state_d = ISSUE;
            end
            // A done pulse seen during ISSUE belongs to nothing we issued yet.
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (i_exec_done) begin
                    wd_d = '0;
                    if (i_end_of_code) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else if (i_return_pc) begin
                        if (stk_empty) begin
                            state_d    = ERROR;
                            error_d    = 1'b1;
                            err_code_d = ERR_STK_UNF;
                        end else begin
                            stk_pop = 1'b1;
                            pc_d    = stk_top;
                            state_d = FETCH;
                        end
                    end else if (i_jump) begin
                        if (stk_full) begin
                            state_d    = ERROR;
                            error_d    = 1'b1;
                            err_code_d = ERR_STK_OVF;
                        end else begin
                            stk_push = 1'b1;
                            pc_d     = jump_target;
                            state_d  = FETCH;
                        end
                    end else begin
                        pc_d    = pc_inc;
                        state_d = FETCH;
                    end
                end else if (wd_q == WD_W'(TMO_CYC - 1)) begin
                    wd_d       = '0;
                    state_d    = ERROR;
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        imem_rd_d = (state_d == FETCH);
        execute_d = (state_d == ISSUE);
        busy_d    = state_is_busy(state_d);
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            wd_q       <= '0;
            imem_rd_q  <= 1'b0;
            execute_q  <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            wd_q       <= wd_d;
            imem_rd_q  <= imem_rd_d;
            execute_q  <= execute_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    assign o_imem_rd   = imem_rd_q;
    assign o_imem_addr = pc_q;
    assign o_execute   = execute_q;
    assign o_op_code   = ir_q[OPC_LSB +: OPC_W];
    assign o_operand1  = ir_q[OP1_LSB +: OPND_W];
    assign o_operand2  = ir_q[OP2_LSB +: OPND_W];
    assign o_pc        = pc_q;
    assign o_busy      = busy_q;
    assign o_halted    = halted_q;
    assign o_error     = error_q;
    assign o_err_code  = err_code_q;

endmodule
